// File: rtl/apb_pkg.sv
// Shared types and widths for the APB arbiter and its round-robin picker.
package apb_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int WAIT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10
  } apb_state_e;

  // Transfer captured from the winning requester at grant time
  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } apb_req_t;

  // Completion data returned to the requester
  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
  } apb_rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first asserted request at or above i_ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  // Scan from the pointer upward; the first hit wins and masks the rest
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      if (!o_any && i_req[(int'(i_ptr) + off) % NREQ]) begin
        o_any = 1'b1;
        o_gnt[(int'(i_ptr) + off) % NREQ] = 1'b1;
        o_idx = IW'((int'(i_ptr) + off) % NREQ);
      end
    end
  end

endmodule

// File: rtl/apb_arbiter.sv
// Multi-requester APB master: round-robin grant, one transfer at a time,
// wait-state timeout, registered one-hot completion back to the winner.
module apb_arbiter
  import apb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                     pclk,
  input  logic                     preset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic [ADDR_W-1:0]        paddr,
  output logic                     psel,
  output logic                     penable,
  output logic                     pwrite,
  output logic [DATA_W-1:0]        pwdata,
  input  logic [DATA_W-1:0]        prdata,
  input  logic                     pready,
  input  logic                     pslverr
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  apb_state_e        r_state, w_state_nxt;
  logic [IW-1:0]     r_ptr, r_gidx, w_gidx, w_ptr_nxt;
  logic [NREQ-1:0]   w_gnt, r_rsp_valid, w_rsp_oh;
  logic              w_any, w_grant, w_done, w_tmo, w_busy;
  logic [WAIT_W-1:0] r_wait;
  apb_req_t          r_xfer, w_xfer_sel;
  apb_rsp_t          r_rsp;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_gidx),
    .o_any (w_any)
  );

  // Fields of the current round-robin winner
  assign w_xfer_sel.write = req_write[w_gidx];
  assign w_xfer_sel.addr  = req_addr[int'(w_gidx)*ADDR_W +: ADDR_W];
  assign w_xfer_sel.wdata = req_wdata[int'(w_gidx)*DATA_W +: DATA_W];

  assign w_ptr_nxt = (w_gidx == IW'(NREQ-1)) ? '0 : w_gidx + IW'(1);
  assign w_rsp_oh  = NREQ'(1) << r_gidx;

  // State register
  always_ff @(posedge pclk) begin
    if (preset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state, bus strobes and grant/completion events
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_done      = 1'b0;
    w_tmo       = 1'b0;
    psel        = 1'b0;
    penable     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        psel        = 1'b1;
        w_state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        // pready has priority over a timeout landing in the same cycle
        if (pready) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_wait == WAIT_W'(TIMEOUT-1)) begin
          w_tmo       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign req_ready = w_grant ? w_gnt : '0;

  // Address/data phase signals are forced to zero whenever the bus is idle
  assign w_busy = (r_state != ST_IDLE);
  assign paddr  = w_busy ? r_xfer.addr  : '0;
  assign pwrite = w_busy ? r_xfer.write : 1'b0;
  assign pwdata = w_busy ? r_xfer.wdata : '0;

  // Capture the winner and advance the round-robin pointer past it
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_xfer <= '0;
      r_gidx <= '0;
      r_ptr  <= '0;
    end else if (w_grant) begin
      r_xfer <= w_xfer_sel;
      r_gidx <= w_gidx;
      r_ptr  <= w_ptr_nxt;
    end
  end

  // Wait counter: cleared in SETUP, counts ACCESS cycles without pready
  always_ff @(posedge pclk) begin
    if (preset)                              r_wait <= '0;
    else if (r_state == ST_SETUP)            r_wait <= '0;
    else if (r_state == ST_ACCESS && !pready) r_wait <= r_wait + WAIT_W'(1);
  end

  // Completion pulse; data/err hold until the next completion
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_rsp_valid <= '0;
      r_rsp       <= '0;
    end else begin
      r_rsp_valid <= '0;
      if (w_done) begin
        r_rsp_valid <= w_rsp_oh;
        r_rsp.rdata <= r_xfer.write ? '0 : prdata;
        r_rsp.err   <= pslverr;
      end else if (w_tmo) begin
        r_rsp_valid <= w_rsp_oh;
        r_rsp.rdata <= '0;
        r_rsp.err   <= 1'b1;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp.rdata;
  assign rsp_err   = r_rsp.err;

endmodule

// File: doc/apb_arbiter.md
APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter TIMEOUT, default 255, giving the maximum ACCESS cycles before forced termination (1..255).
REQ-003 The block SHALL have these ports (name direction width meaning):
- pclk  in  1  single clock, rising edge
- preset  in  1  synchronous active-high reset
- req_valid  in  NREQ  per-requester transfer request
- req_write  in  NREQ  per-requester direction, 1=write
- req_addr  in  NREQ*8  per-requester address, slice i = [8i+7:8i]
- req_wdata  in  NREQ*32  per-requester write data, slice i = [32i+31:32i]
- req_ready  out  NREQ  one-hot acceptance pulse
- rsp_valid  out  NREQ  one-hot completion pulse
- rsp_rdata  out  32  read data, shared
- rsp_err  out  1  error flag for the completing transfer
- paddr  out  8  APB address
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- pwdata  out  32  APB write data
- prdata  in  32  APB read data
- pready  in  1  APB completer ready
- pslverr  in  1  APB completer error

Function
REQ-004 The block SHALL run a three-state FSM: IDLE, SETUP, ACCESS.
REQ-005 In IDLE with any req_valid high, the block SHALL pick one requester by round-robin, pulse its req_ready for that cycle, latch its write/addr/wdata, and go to SETUP.
REQ-006 Round-robin SHALL search from index ptr upward, wrapping NREQ-1 to 0; after a grant to index g, ptr SHALL become (g+1) mod NREQ.
REQ-007 Requests arriving in the same cycle SHALL be resolved by REQ-006 alone; non-granted requesters stay pending with no req_ready.
REQ-008 SETUP SHALL last exactly one cycle with psel=1, penable=0; the next state is ACCESS.
REQ-009 ACCESS SHALL drive psel=1, penable=1 and hold there while pready=0.
REQ-010 In all non-IDLE states, paddr/pwrite/pwdata SHALL equal the latched values.
REQ-011 In IDLE, psel, penable, pwrite SHALL be 0, and paddr, pwdata SHALL be 0.
REQ-012 In ACCESS with pready=1, the block SHALL return to IDLE.
- On the next cycle it SHALL pulse rsp_valid[g] for one cycle with rsp_err=pslverr.
- rsp_rdata SHALL be prdata for reads and 0 for writes.
REQ-013 An 8-bit wait counter SHALL clear on entering ACCESS and increment each ACCESS cycle with pready=0.
- When it reaches TIMEOUT, the block SHALL go to IDLE and pulse rsp_valid[g] next cycle with rsp_err=1, rsp_rdata=0.
- pready=1 in the same cycle as the counter reaching TIMEOUT SHALL count as normal completion (pready wins).
REQ-014 Every transfer SHALL pass through at least one IDLE cycle, so the minimum period is 3 cycles per transfer.
REQ-015 rsp_valid/rsp_rdata/rsp_err SHALL be registered; rsp_rdata and rsp_err SHALL hold their value until the next rsp_valid.
REQ-016 Completion latency SHALL be 3 + wait cycles, counted from the req_ready cycle to the rsp_valid cycle.
REQ-017 The block SHALL ignore req_valid deassertion after acceptance; the latched transfer completes.

Reset
REQ-018 With preset=1 at a pclk edge, the block SHALL set state=IDLE, ptr=0, wait counter=0, and latched addr/wdata/write=0.
REQ-019 The same reset edge SHALL clear rsp_valid, rsp_rdata and rsp_err to 0, with no rsp_valid for the aborted transfer.
REQ-020 Reset during SETUP or ACCESS SHALL drop psel/penable on the cycle after the edge.
REQ-021 All reset behaviour SHALL be synchronous; preset SHALL have no effect between edges.

Structure
REQ-022 State encoding (IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10) and the widths 8/32 SHALL live in shared package apb_pkg.
REQ-023 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: request vector, ptr; outputs: one-hot grant, grant index, any).

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Single write: req 0 write addr 0x10 data 0xDEADBEEF, pready=1 immediately -> psel 2 cycles, penable 1 cycle, paddr=0x10, rsp_valid[0] 3 cycles after req_ready, rsp_err=0.
- Read with waits: req 2 read addr 0x20, pready after 4 ACCESS cycles, prdata=0x12345678 -> rsp_rdata=0x12345678, latency 7 cycles.
- Fairness: all 4 req_valid held high from reset -> grants in order 0,1,2,3,0, each separated by >=3 cycles.
- Timeout: TIMEOUT=5, pready held 0 -> exit after 5 ACCESS cycles, rsp_err=1, rsp_rdata=0; pready=1 on the 5th cycle instead -> normal completion with rsp_err=0.
- Slave error: pslverr=1 with pready=1 on a write -> rsp_err=1.
- Reset in ACCESS: preset pulsed mid-wait -> psel=0 next cycle, no rsp_valid, next grant starts from index 0.
